// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx
// -----------------------------------------------------------------------------
// Serial bit-stream transmitter. It accepts a pattern word, a bit length and a
// repeat count through a valid/ready request. It then shifts the pattern out
// MSB-first, one bit per clock, and inserts GAP idle cycles between copies.
// It drives the single-bit serial input of the Mealy sequence detectors.
//
// Optional feature (macro SERIAL_PATTERN_TX_MATCH_EN):
//   Adds an internal overlapping 1,1,0 detector on the transmitted stream and
//   a saturating match_cnt output.
//
// Ports:
//   clk        in   1            system clock, rising edge
//   reset      in   1            synchronous, active-high reset
//   req_valid  in   1            request present
//   req_ready  out  1            block can accept a request (registered)
//   pat        in   W            pattern; bits [pat_len-1:0] sent MSB-first
//   pat_len    in   LEN_W        bits per copy (0 or >W means W)
//   rep        in   CNT_W        number of copies (0 means 1)
//   x_out      out  1            serial data bit, 0 whenever x_valid=0
//   x_valid    out  1            x_out carries a pattern bit this cycle
//   busy       out  1            transmission in progress
//   done       out  1            one-cycle pulse after the final bit
//   match_cnt  out  CNT_W+LEN_W  1,1,0 occurrences (only with the macro)
// -----------------------------------------------------------------------------
module serial_pattern_tx #(
  parameter int W     = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [W-1:0]     pat,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [CNT_W-1:0] rep,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             done
`ifdef SERIAL_PATTERN_TX_MATCH_EN
  ,
  output logic [CNT_W+LEN_W-1:0] match_cnt
`endif
);

  // The gap counter needs at least one bit, even when GAP is 0 or 1.
  localparam int GAP_W = (GAP < 2) ? 1 : $clog2(GAP);
  localparam bit HAS_GAP = (GAP > 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [LEN_W-1:0] bit_q, bit_d;     // index of the bit currently on x_out
  logic [CNT_W-1:0] copy_q, copy_d;   // copies completed before the current one
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             x_out_q, x_out_d;
  logic             x_valid_q, x_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic             accept_s;
  logic [LEN_W-1:0] len_norm_s;
  logic [CNT_W-1:0] rep_norm_s;

  // Select bit idx of v. Indices outside the vector return 0.
  function automatic logic get_bit(input logic [W-1:0] v, input logic [LEN_W-1:0] idx);
    logic b;
    b = 1'b0;
    for (int i = 0; i < W; i++) begin
      b = b | (v[i] & (idx == LEN_W'(i)));
    end
    return b;
  endfunction

  assign accept_s   = req_valid & ready_q;
  assign len_norm_s = ((pat_len == {LEN_W{1'b0}}) || (pat_len > LEN_W'(W))) ? LEN_W'(W) : pat_len;
  assign rep_norm_s = (rep == {CNT_W{1'b0}}) ? CNT_W'(1) : rep;

  // Next-state and next-output logic for the transmit FSM.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    rep_d     = rep_q;
    bit_d     = bit_q;
    copy_d    = copy_q;
    gap_d     = gap_q;
    x_out_d   = 1'b0;
    x_valid_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    ready_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          pat_d     = pat;
          len_d     = len_norm_s;
          rep_d     = rep_norm_s;
          bit_d     = len_norm_s - LEN_W'(1);
          copy_d    = {CNT_W{1'b0}};
          gap_d     = {GAP_W{1'b0}};
          x_valid_d = 1'b1;
          x_out_d   = get_bit(pat, len_norm_s - LEN_W'(1));
          busy_d    = 1'b1;
          state_d   = ST_SHIFT;
        end else begin
          ready_d = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (bit_q != {LEN_W{1'b0}}) begin
          bit_d     = bit_q - LEN_W'(1);
          x_valid_d = 1'b1;
          x_out_d   = get_bit(pat_q, bit_q - LEN_W'(1));
          busy_d    = 1'b1;
        end else if (copy_q != (rep_q - CNT_W'(1))) begin
          copy_d = copy_q + CNT_W'(1);
          busy_d = 1'b1;
          if (HAS_GAP) begin
            gap_d   = {GAP_W{1'b0}};
            state_d = ST_GAP;
          end else begin
            // Back-to-back copies: restart at the MSB without an idle cycle.
            bit_d     = len_q - LEN_W'(1);
            x_valid_d = 1'b1;
            x_out_d   = get_bit(pat_q, len_q - LEN_W'(1));
          end
        end else begin
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_GAP: begin
        busy_d = 1'b1;
        if (gap_q == GAP_W'(GAP - 1)) begin
          bit_d     = len_q - LEN_W'(1);
          x_valid_d = 1'b1;
          x_out_d   = get_bit(pat_q, len_q - LEN_W'(1));
          state_d   = ST_SHIFT;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched request fields and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pat_q     <= {W{1'b0}};
      len_q     <= {LEN_W{1'b0}};
      rep_q     <= {CNT_W{1'b0}};
      bit_q     <= {LEN_W{1'b0}};
      copy_q    <= {CNT_W{1'b0}};
      gap_q     <= {GAP_W{1'b0}};
      x_out_q   <= 1'b0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      rep_q     <= rep_d;
      bit_q     <= bit_d;
      copy_q    <= copy_d;
      gap_q     <= gap_d;
      x_out_q   <= x_out_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign x_out     = x_out_q;
  assign x_valid   = x_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign req_ready = ready_q;

`ifdef SERIAL_PATTERN_TX_MATCH_EN
  typedef enum logic [1:0] {
    DET_S0  = 2'd0,   // no useful prefix
    DET_S1  = 2'd1,   // seen 1
    DET_S11 = 2'd2    // seen 1,1 (stays here on further 1s)
  } det_t;

  localparam logic [CNT_W+LEN_W-1:0] CNT_MAX = {(CNT_W+LEN_W){1'b1}};

  det_t                   det_q, det_d;
  logic [CNT_W+LEN_W-1:0] cnt_q, cnt_d;

  // Detector next state: it observes the registered serial output and
  // ignores gap cycles.
  always_comb begin
    det_d = det_q;
    cnt_d = cnt_q;
    if ((state_q == ST_IDLE) && accept_s) begin
      det_d = DET_S0;
      cnt_d = {(CNT_W+LEN_W){1'b0}};
    end else if (x_valid_q) begin
      case (det_q)
        DET_S0:  det_d = x_out_q ? DET_S1 : DET_S0;
        DET_S1:  det_d = x_out_q ? DET_S11 : DET_S0;
        DET_S11: begin
          if (x_out_q) begin
            det_d = DET_S11;
          end else begin
            det_d = DET_S0;
            if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + (CNT_W+LEN_W)'(1);
            end else begin
              cnt_d = cnt_q;
            end
          end
        end
        default: det_d = DET_S0;
      endcase
    end else begin
      det_d = det_q;
    end
  end

  // Detector state and saturating match counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      det_q <= DET_S0;
      cnt_q <= {(CNT_W+LEN_W){1'b0}};
    end else begin
      det_q <= det_d;
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Testbench for serial_pattern_tx. Two instances share the request inputs:
// u_dut1 uses GAP=1 and u_dut0 uses GAP=0. A queue-based reference model
// builds the expected per-cycle output vector from the stream rules.
module tb_serial_pattern_tx;

  localparam int W     = 8;
  localparam int LEN_W = 4;
  localparam int CNT_W = 4;

  typedef logic [4:0] obs_t;   // {x_valid, x_out, busy, done, req_ready}
  typedef obs_t obs_q_t[$];

  localparam obs_t IDLE_OBS = 5'b00001;

  logic             clk;
  logic             reset;
  logic             req_valid;
  logic [W-1:0]     pat;
  logic [LEN_W-1:0] pat_len;
  logic [CNT_W-1:0] rep;

  logic req_ready1, x_out1, x_valid1, busy1, done1;
  logic req_ready0, x_out0, x_valid0, busy0, done0;
`ifdef SERIAL_PATTERN_TX_MATCH_EN
  logic [CNT_W+LEN_W-1:0] match_cnt1, match_cnt0;
`endif

  int checks;
  int passed;

  serial_pattern_tx #(.W(W), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready1),
    .pat(pat), .pat_len(pat_len), .rep(rep),
    .x_out(x_out1), .x_valid(x_valid1), .busy(busy1), .done(done1)
`ifdef SERIAL_PATTERN_TX_MATCH_EN
    , .match_cnt(match_cnt1)
`endif
  );

  serial_pattern_tx #(.W(W), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP(0)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready0),
    .pat(pat), .pat_len(pat_len), .rep(rep),
    .x_out(x_out0), .x_valid(x_valid0), .busy(busy0), .done(done0)
`ifdef SERIAL_PATTERN_TX_MATCH_EN
    , .match_cnt(match_cnt0)
`endif
  );

  always #5 clk = ~clk;

  wire obs_t obs1 = {x_valid1, x_out1, busy1, done1, req_ready1};
  wire obs_t obs0 = {x_valid0, x_out0, busy0, done0, req_ready0};

  // Expected output vector for every cycle after the accept edge, up to and
  // including the done cycle.
  function automatic obs_q_t model(input logic [7:0] p, input logic [3:0] l,
                                   input logic [3:0] r, input int g);
    obs_q_t q;
    int el, er;
    el = (l == 4'd0 || l > 4'd8) ? 8 : int'(l);
    er = (r == 4'd0) ? 1 : int'(r);
    for (int c = 0; c < er; c++) begin
      for (int k = el - 1; k >= 0; k--) q.push_back({1'b1, p[k], 1'b1, 1'b0, 1'b0});
      if (c < er - 1) for (int j = 0; j < g; j++) q.push_back(5'b00100);
    end
    q.push_back(5'b00011);
    return q;
  endfunction

  // Count of (overlapping) 1,1,0 windows in the valid bits of a stream.
  function automatic int count_110(input obs_q_t q);
    logic [2:0] hist;
    int n;
    hist = 3'b000;
    n = 0;
    foreach (q[i]) begin
      if (q[i][4]) begin
        hist = {hist[1:0], q[i][3]};
        if (hist == 3'b110) n++;
      end
    end
    return n;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs1 !== IDLE_OBS) $display("FAIL reset_gap1: got %b want %b", obs1, IDLE_OBS);
    else passed++;
    checks++;
    if (obs0 !== IDLE_OBS) $display("FAIL reset_gap0: got %b want %b", obs0, IDLE_OBS);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_streams();
    logic [7:0] tp [7];
    logic [3:0] tl [7];
    logic [3:0] tr [7];
    obs_q_t q1, q0;
    logic [7:0] p;
    logic [3:0] l, r;
    int n;
    tp = '{8'h06, 8'h06, 8'hA5, 8'h06, 8'hDB, 8'h3C, 8'h81};
    tl = '{4'd3,  4'd3,  4'd0,  4'd3,  4'd8,  4'd9,  4'd1};
    tr = '{4'd1,  4'd2,  4'd0,  4'd3,  4'd1,  4'd1,  4'd4};
    for (int t = 0; t < 27; t++) begin
      if (t < 7) begin
        p = tp[t]; l = tl[t]; r = tr[t];
      end else begin
        p = 8'($urandom);
        l = 4'($urandom_range(0, 15));
        r = 4'($urandom_range(0, 15));
      end
      req_valid = 1'b1; pat = p; pat_len = l; rep = r;
      @(posedge clk);
      q1 = model(p, l, r, 1);
      q0 = model(p, l, r, 0);
      n = (q1.size() > q0.size()) ? q1.size() : q0.size();
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        if (i < q1.size()) begin
          checks++;
          if (obs1 !== q1[i])
            $display("FAIL stream%0d_gap1 cycle %0d: got %b want %b", t, i + 1, obs1, q1[i]);
          else passed++;
        end
        if (i < q0.size()) begin
          checks++;
          if (obs0 !== q0[i])
            $display("FAIL stream%0d_gap0 cycle %0d: got %b want %b", t, i + 1, obs0, q0[i]);
          else passed++;
        end
        if (i == 0) begin
          // Fields change after the accept; the stream must not follow them.
          req_valid = 1'b0;
          pat = 8'($urandom); pat_len = 4'($urandom); rep = 4'($urandom);
        end
      end
`ifdef SERIAL_PATTERN_TX_MATCH_EN
      checks++;
      if (match_cnt1 !== 8'(count_110(q1)))
        $display("FAIL match%0d_gap1: got %0d want %0d", t, match_cnt1, count_110(q1));
      else passed++;
      checks++;
      if (match_cnt0 !== 8'(count_110(q0)))
        $display("FAIL match%0d_gap0: got %0d want %0d", t, match_cnt0, count_110(q0));
      else passed++;
`endif
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    obs_q_t qa, qb;
    logic [7:0] pb;
    logic [3:0] lb, rb;
    obs_t exp;
    req_valid = 1'b1;
    pat = 8'($urandom); pat_len = 4'($urandom_range(1, 8)); rep = 4'($urandom_range(1, 3));
    @(posedge clk);
    qa = model(pat, pat_len, rep, 1);
    pb = 8'($urandom); lb = 4'($urandom_range(1, 8)); rb = 4'($urandom_range(1, 3));
    qb = model(pb, lb, rb, 1);
    for (int i = 0; i < qa.size() + qb.size(); i++) begin
      @(negedge clk);
      exp = (i < qa.size()) ? qa[i] : qb[i - qa.size()];
      checks++;
      if (obs1 !== exp) $display("FAIL back_to_back cycle %0d: got %b want %b", i + 1, obs1, exp);
      else passed++;
      if (i == 0) begin
        pat = pb; pat_len = lb; rep = rb;
      end
      if (i == qa.size()) req_valid = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    obs_q_t q;
    req_valid = 1'b1; pat = 8'($urandom); pat_len = 4'd8; rep = 4'd1;
    @(posedge clk);
    q = model(pat, pat_len, rep, 1);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (obs1 !== q[0]) $display("FAIL reset_mid cycle 1: got %b want %b", obs1, q[0]);
    else passed++;
    @(negedge clk);
    checks++;
    if (obs1 !== q[1]) $display("FAIL reset_mid cycle 2: got %b want %b", obs1, q[1]);
    else passed++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (obs1 !== IDLE_OBS) $display("FAIL reset_mid_abort: got %b want %b", obs1, IDLE_OBS);
    else passed++;
    checks++;
    if (obs0 !== IDLE_OBS) $display("FAIL reset_mid_abort_gap0: got %b want %b", obs0, IDLE_OBS);
    else passed++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (obs1 !== IDLE_OBS) $display("FAIL reset_mid_idle %0d: got %b want %b", i, obs1, IDLE_OBS);
      else passed++;
    end
    req_valid = 1'b1; pat = 8'($urandom); pat_len = 4'($urandom); rep = 4'($urandom_range(0, 4));
    @(posedge clk);
    q = model(pat, pat_len, rep, 1);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if (obs1 !== q[i]) $display("FAIL reset_mid_fresh cycle %0d: got %b want %b", i + 1, obs1, q[i]);
      else passed++;
    end
    @(negedge clk);
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    req_valid = 1'b0;
    pat = 8'h00;
    pat_len = 4'd0;
    rep = 4'd0;
    checks = 0;
    passed = 0;
    @(negedge clk);
    test_reset();
    test_streams();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
